// File: rtl/arb3_pkg.sv
// Shared definitions for the 3-source round-robin arbitration stage:
// select codes, the output-register state encoding and the pointer advance.
package arb3_pkg;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb3_state_e;

  // (k+1) mod 3; the unused code 3 folds back to source a
  function automatic logic [1:0] next_ptr(input logic [1:0] k);
    logic [1:0] n;
    case (k)
      SEL_A:   n = SEL_B;
      SEL_B:   n = SEL_C;
      default: n = SEL_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: scans sources starting at ptr and returns
// a one-hot grant plus its 2-bit code (SEL_NONE when nothing is valid).
module rr_pick3
  import arb3_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [2:0] valid,
  output logic [2:0] grant,
  output logic [1:0] grant_code
);

  logic [1:0] order [3];
  logic       found;

  // Priority order ptr, ptr+1, ptr+2 (mod 3); an illegal ptr of 3 behaves as 0
  always_comb begin
    case (ptr)
      SEL_B: begin
        order[0] = SEL_B;
        order[1] = SEL_C;
        order[2] = SEL_A;
      end
      SEL_C: begin
        order[0] = SEL_C;
        order[1] = SEL_A;
        order[2] = SEL_B;
      end
      default: begin
        order[0] = SEL_A;
        order[1] = SEL_B;
        order[2] = SEL_C;
      end
    endcase
  end

  always_comb begin
    grant      = 3'b000;
    grant_code = SEL_NONE;
    found      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && valid[order[i]]) begin
        grant[order[i]] = 1'b1;
        grant_code      = order[i];
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb3_stage.sv
// Registered 3-source round-robin arbiter with a one-entry output register.
// Define ARB3_STATS_EN to add saturating per-source grant counters and stats_clr.
module rr_arb3_stage
  import arb3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] c_data,
  input  logic             c_valid,
  output logic             c_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_select
`ifdef ARB3_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] a_grants,
  output logic [CNT_W-1:0] b_grants,
  output logic [CNT_W-1:0] c_grants
`endif
);

  arb3_state_e      state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;

  logic [2:0]       grant;
  logic [1:0]       grant_code;
  logic [2:0]       ready;
  logic             accept;
  logic             xfer;

  rr_pick3 u_pick (
    .ptr        (ptr_q),
    .valid      ({c_valid, b_valid, a_valid}),
    .grant      (grant),
    .grant_code (grant_code)
  );

  // Readys are gated by rst_n so nothing is consumed on a reset edge
  assign accept  = (state_q == EMPTY) || out_ready;
  assign ready   = grant & {3{accept & rst_n}};
  assign xfer    = |ready;
  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign c_ready = ready[2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      state_d = FULL;
      sel_d   = grant_code;
      ptr_d   = next_ptr(grant_code);
      case (grant_code)
        SEL_B:   data_d = b_data;
        SEL_C:   data_d = c_data;
        default: data_d = a_data;
      endcase
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
      sel_d   = SEL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= SEL_A;
      data_q  <= '0;
      sel_q   <= SEL_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = (state_q == FULL);
  assign out_select = sel_q;

`ifdef ARB3_STATS_EN
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  // A clear coinciding with a transfer counts that transfer, hence 1 not 0
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (stats_clr) begin
        cnt_d[k] = ready[k] ? CNT_W'(1) : '0;
      end else if (ready[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign a_grants = cnt_q[0];
  assign b_grants = cnt_q[1];
  assign c_grants = cnt_q[2];
`endif

endmodule

// File: tb/tb_rr_arb3_stage.sv
// Directed self-checking bench for rr_arb3_stage (WIDTH=8, CNT_W=2); the
// grant-counter steps run only when ARB3_STATS_EN is defined.
module tb_rr_arb3_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a_data, b_data, c_data;
  logic             a_valid, b_valid, c_valid;
  logic             a_ready, b_ready, c_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_select;
`ifdef ARB3_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] a_grants, b_grants, c_grants;
`endif

  int checks;
  int failures;

  rr_arb3_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .c_data     (c_data),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_select (out_select)
`ifdef ARB3_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .a_grants   (a_grants),
    .b_grants   (b_grants),
    .c_grants   (c_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReadys(input string tag, input logic [2:0] exp);
    checkOutput(tag, {29'd0, c_ready, b_ready, a_ready}, {29'd0, exp});
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [1:0] sel, input logic [7:0] d);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    checkOutput({tag, "_select"}, {30'd0, out_select}, {30'd0, sel});
    checkOutput({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    a_data    = 8'h11;
    b_data    = 8'h22;
    c_data    = 8'h33;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    c_valid   = 1'b1;
    out_ready = 1'b1;
`ifdef ARB3_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset held for two edges with every source valid
    applyStimulus();
    applyStimulus();
    checkReadys("rst_readys", 3'b000);
    checkOut("rst", 1'b0, 2'd3, 8'h00);

    // Fairness: a, b, c, a with ptr rotating
    rst_n = 1'b1;
    #1;
    checkReadys("first_grant_a", 3'b001);
    applyStimulus();
    checkOut("fair0", 1'b1, 2'd0, 8'h11);
    checkReadys("ptr1_grants_b", 3'b010);
    applyStimulus();
    checkOut("fair1", 1'b1, 2'd1, 8'h22);
    checkReadys("ptr2_grants_c", 3'b100);
    applyStimulus();
    checkOut("fair2", 1'b1, 2'd2, 8'h33);
    applyStimulus();
    checkOut("fair3", 1'b1, 2'd0, 8'h11);

    // Backpressure on 0x22: four stalled cycles, ptr stays at c
    applyStimulus();
    checkOut("bp_load", 1'b1, 2'd1, 8'h22);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkReadys("bp_readys", 3'b000);
      applyStimulus();
      checkOut("bp_hold", 1'b1, 2'd1, 8'h22);
    end
    out_ready = 1'b1;
    #1;
    checkReadys("bp_release_c", 3'b100);
    applyStimulus();
    checkOut("bp_next", 1'b1, 2'd2, 8'h33);

    // Skip/wrap: only c valid at ptr=0, then a and b valid
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_data  = 8'h5A;
    #1;
    checkReadys("skip_c_ready", 3'b100);
    applyStimulus();
    checkOut("skip_c", 1'b1, 2'd2, 8'h5A);
    a_valid = 1'b1;
    b_valid = 1'b1;
    c_valid = 1'b0;
    #1;
    checkReadys("wrap_a_ready", 3'b001);
    applyStimulus();
    checkOut("wrap_a", 1'b1, 2'd0, 8'h11);

    // Drain to EMPTY, idle keeps ptr=1
    a_valid = 1'b0;
    b_valid = 1'b0;
    applyStimulus();
    checkOut("drain", 1'b0, 2'd3, 8'h11);
    applyStimulus();
    checkOut("idle", 1'b0, 2'd3, 8'h11);
    a_valid = 1'b1;
    c_valid = 1'b1;
    #1;
    checkReadys("idle_ptr_kept", 3'b100);
    applyStimulus();
    checkOut("refill_c", 1'b1, 2'd2, 8'h5A);

    // Reset while FULL
    rst_n = 1'b0;
    #1;
    checkReadys("rst_full_readys", 3'b000);
    applyStimulus();
    checkOut("rst_full", 1'b0, 2'd3, 8'h00);
    rst_n = 1'b1;
    #1;
    checkReadys("post_rst_a", 3'b001);

`ifdef ARB3_STATS_EN
    // Saturation at CNT_W=2 after five grants to a, then clear-with-transfer
    c_valid = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("a_grants_sat", {30'd0, a_grants}, 32'd3);
    checkOutput("b_grants_zero", {30'd0, b_grants}, 32'd0);
    checkOutput("c_grants_zero", {30'd0, c_grants}, 32'd0);
    stats_clr = 1'b1;
    applyStimulus();
    stats_clr = 1'b0;
    checkOutput("a_grants_clr_xfer", {30'd0, a_grants}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
